// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the integer register file.
// Two writeback sources (ALU and memory load) compete for the single write
// port. Conflicts are resolved round-robin, and the winner's write is
// registered for one cycle. A pending-write scoreboard is marked at issue
// and cleared at writeback, and it drives the decode-stage hazard flags.
module regfile_wb_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_valid,
   input  logic [4:0]  a_addr,
   input  logic [31:0] a_data,
   output logic        a_ready,
   input  logic        m_valid,
   input  logic [4:0]  m_addr,
   input  logic [31:0] m_data,
   output logic        m_ready,
   input  logic        iss_valid,
   input  logic [4:0]  iss_addr,
   input  logic [4:0]  rd_addr_a,
   input  logic [4:0]  rd_addr_b,
   output logic        hazard_a,
   output logic        hazard_b,
   output logic        wr_en,
   output logic [4:0]  wr_addr,
   output logic [31:0] wr_data,
   output logic [31:0] busy
);

   // Round-robin pointer: 1 means memory wins the next conflict.
   logic        r_prio_m;
   logic        r_wr_en;
   logic [4:0]  r_wr_addr;
   logic [31:0] r_wr_data;
   logic [31:0] r_busy;

   logic        w_a_grant;
   logic        w_m_grant;
   logic        w_xfer;
   logic        w_write;
   logic [4:0]  w_xfer_addr;
   logic [31:0] w_xfer_data;
   logic [31:0] w_set;
   logic [31:0] w_clr;
   logic [31:0] w_busy_next;

   // Grant selection: a lone requester wins outright, and a conflict follows the pointer.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      w_a_grant = 1'b0;
      w_m_grant = 1'b0;
      if (!rst) begin
         if (a_valid && m_valid) begin
            if (r_prio_m) begin
               w_m_grant = 1'b1;
            end else begin
               w_a_grant = 1'b1;
            end
         end else begin
            w_a_grant = a_valid;
            w_m_grant = m_valid;
         end
      end
   end

   // Mux the granted request onto the write path. Address 0 is consumed but never written.
   always_comb begin
      w_xfer      = w_a_grant | w_m_grant;
      w_xfer_addr = w_m_grant ? m_addr : a_addr;
      w_xfer_data = w_m_grant ? m_data : a_data;
      w_write     = w_xfer && (w_xfer_addr != 5'd0);
   end

   // Scoreboard update masks. The clear is applied before the set, so the set wins on a collision.
   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (iss_valid && (iss_addr != 5'd0)) begin
         w_set[iss_addr] = 1'b1;
      end
      if (w_write) begin
         w_clr[w_xfer_addr] = 1'b1;
      end
      w_busy_next = ((r_busy & ~w_clr) | w_set) & 32'hFFFF_FFFE;
   end

   // Writeback register and round-robin pointer. The pointer moves only on a transfer.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
      if (rst) begin
         r_prio_m  <= 1'b1;
         r_wr_en   <= 1'b0;
         r_wr_addr <= 5'd0;
         r_wr_data <= 32'd0;
      end else begin
         r_wr_en <= w_write;
         if (w_write) begin
            r_wr_addr <= w_xfer_addr;
            r_wr_data <= w_xfer_data;
         end
         if (w_xfer) begin
            r_prio_m <= w_a_grant;
         end
      end
   end

   // Pending-write scoreboard: set at issue and cleared at writeback.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the scoreboard is architecturally visible, so every bit is reset rather than left unknown.
      if (rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_next;
      end
   end

   assign a_ready  = w_a_grant;
   assign m_ready  = w_m_grant;
   assign wr_en    = r_wr_en;
   assign wr_addr  = r_wr_addr;
   assign wr_data  = r_wr_data;
   assign busy     = r_busy;
   assign hazard_a = r_busy[rd_addr_a];
   assign hazard_b = r_busy[rd_addr_b];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_regfile_wb_arbiter;

   logic        clk;
   logic        rst;
   logic        a_valid;
   logic [4:0]  a_addr;
   logic [31:0] a_data;
   logic        a_ready;
   logic        m_valid;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   logic        m_ready;
   logic        iss_valid;
   logic [4:0]  iss_addr;
   logic [4:0]  rd_addr_a;
   logic [4:0]  rd_addr_b;
   logic        hazard_a;
   logic        hazard_b;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [31:0] busy;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model state.
   bit          m_busy [32];
   bit          m_last_a;
   bit          m_wr_en;
   logic [4:0]  m_wr_addr;
   logic [31:0] m_wr_data;
   bit          acc_a;
   bit          acc_m;

   regfile_wb_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .a_valid   (a_valid),
      .a_addr    (a_addr),
      .a_data    (a_data),
      .a_ready   (a_ready),
      .m_valid   (m_valid),
      .m_addr    (m_addr),
      .m_data    (m_data),
      .m_ready   (m_ready),
      .iss_valid (iss_valid),
      .iss_addr  (iss_addr),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .hazard_a  (hazard_a),
      .hazard_b  (hazard_b),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_busy();
      logic [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = m_busy[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_last_a  = 1'b1;  // as if the ALU was granted last, so memory wins the first conflict
      m_wr_en   = 1'b0;
      m_wr_addr = 5'd0;
      m_wr_data = 32'd0;
      acc_a     = 1'b0;
      acc_m     = 1'b0;
   endtask

   // One clock cycle: compare all outputs at the falling edge, then advance the model past the rising edge.
   task automatic cycle_check();
      bit          ea;
      bit          em;
      logic [4:0]  addr;
      logic [31:0] data;
      bit          iv;
      logic [4:0]  ia;
      @(negedge clk);
      ea = 1'b0;
      em = 1'b0;
      if (a_valid && m_valid) begin
         if (m_last_a) em = 1'b1;
         else          ea = 1'b1;
      end else begin
         ea = a_valid;
         em = m_valid;
      end
      check("a_ready",  {31'd0, a_ready},  {31'd0, ea});
      check("m_ready",  {31'd0, m_ready},  {31'd0, em});
      check("hazard_a", {31'd0, hazard_a}, {31'd0, (rd_addr_a != 5'd0) && m_busy[rd_addr_a]});
      check("hazard_b", {31'd0, hazard_b}, {31'd0, (rd_addr_b != 5'd0) && m_busy[rd_addr_b]});
      check("wr_en",    {31'd0, wr_en},    {31'd0, m_wr_en});
      check("wr_addr",  {27'd0, wr_addr},  {27'd0, m_wr_addr});
      check("wr_data",  wr_data,           m_wr_data);
      check("busy",     busy,              model_busy());
      addr  = ea ? a_addr : m_addr;
      data  = ea ? a_data : m_data;
      iv    = iss_valid;
      ia    = iss_addr;
      acc_a = ea;
      acc_m = em;
      @(posedge clk);
      #1;
      m_wr_en = 1'b0;
      if (ea || em) begin
         m_last_a = ea;
         if (addr != 5'd0) begin
            m_wr_en       = 1'b1;
            m_wr_addr     = addr;
            m_wr_data     = data;
            m_busy[addr]  = 1'b0;
         end
      end
      if (iv && ia != 5'd0) m_busy[ia] = 1'b1;
   endtask

   function automatic logic [4:0] rnd_addr();
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 10) return 5'd0;
      if (r < 55) return 5'($urandom_range(1, 7));
      return 5'($urandom_range(1, 31));
   endfunction

   initial begin
      rst = 1'b1;
      a_valid = 1'b0; a_addr = '0; a_data = '0;
      m_valid = 1'b0; m_addr = '0; m_data = '0;
      iss_valid = 1'b0; iss_addr = '0;
      rd_addr_a = '0; rd_addr_b = '0;
      model_reset();

      // Reset state, released between clock edges.
      #12;
      check("rst_wr_en",   {31'd0, wr_en}, 32'd0);
      check("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
      check("rst_busy",    busy, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // First conflict after reset goes to memory, the next one to the ALU.
      a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hA3A3_0003;
      m_valid = 1'b1; m_addr = 5'd4; m_data = 32'hB4B4_0004;
      #1;
      check("conflict1_m_ready", {31'd0, m_ready}, 32'd1);
      check("conflict1_a_ready", {31'd0, a_ready}, 32'd0);
      cycle_check();
      check("conflict1_wr_addr", {27'd0, wr_addr}, 32'd4);
      m_data = 32'hB4B4_1004;
      #1;
      check("conflict2_a_ready", {31'd0, a_ready}, 32'd1);
      check("conflict2_m_ready", {31'd0, m_ready}, 32'd0);
      cycle_check();
      check("conflict2_wr_en",   {31'd0, wr_en}, 32'd1);
      check("conflict2_wr_addr", {27'd0, wr_addr}, 32'd3);
      check("conflict2_wr_data", wr_data, 32'hA3A3_0003);
      a_valid = 1'b0; m_valid = 1'b0;

      // A lone ALU request is granted in the same cycle and written one cycle later.
      a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h0000_1234;
      #1;
      check("alu_only_a_ready", {31'd0, a_ready}, 32'd1);
      cycle_check();
      check("alu_only_wr_en",   {31'd0, wr_en}, 32'd1);
      check("alu_only_wr_addr", {27'd0, wr_addr}, 32'd5);
      check("alu_only_wr_data", wr_data, 32'h0000_1234);
      a_valid = 1'b0;
      cycle_check();

      // Issue marks r7 busy, and a memory writeback of r7 clears it.
      iss_valid = 1'b1; iss_addr = 5'd7;
      cycle_check();
      iss_valid = 1'b0; rd_addr_a = 5'd7;
      #1;
      check("r7_hazard_a", {31'd0, hazard_a}, 32'd1);
      check("r7_busy",     busy, 32'h0000_0080);
      m_valid = 1'b1; m_addr = 5'd7; m_data = 32'hCAFE_0007;
      cycle_check();
      m_valid = 1'b0;
      #1;
      check("r7_cleared_busy",     busy, 32'd0);
      check("r7_cleared_hazard_a", {31'd0, hazard_a}, 32'd0);

      // Set and clear of the same register in one cycle: the set wins.
      iss_valid = 1'b1; iss_addr = 5'd9;
      cycle_check();
      a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h9999_0009;
      cycle_check();
      iss_valid = 1'b0; a_valid = 1'b0;
      check("r9_setwins_busy",    busy, 32'h0000_0200);
      check("r9_setwins_wr_en",   {31'd0, wr_en}, 32'd1);
      check("r9_setwins_wr_addr", {27'd0, wr_addr}, 32'd9);

      // Writes to r0 are consumed without a write, and issue to r0 is ignored.
      a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hDEAD_0000;
      #1;
      check("r0_a_ready", {31'd0, a_ready}, 32'd1);
      cycle_check();
      a_valid = 1'b0;
      check("r0_wr_en", {31'd0, wr_en}, 32'd0);
      check("r0_busy",  busy, 32'h0000_0200);
      iss_valid = 1'b1; iss_addr = 5'd0;
      cycle_check();
      iss_valid = 1'b0;
      check("r0_iss_busy", busy, 32'h0000_0200);

      // Randomized traffic. Each requester holds its request until accepted.
      acc_a = 1'b0;
      acc_m = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (!a_valid || acc_a) begin
            a_valid = ($urandom_range(0, 99) < 60);
            a_addr  = rnd_addr();
            a_data  = $urandom;
         end
         if (!m_valid || acc_m) begin
            m_valid = ($urandom_range(0, 99) < 60);
            m_addr  = rnd_addr();
            m_data  = $urandom;
         end
         iss_valid = ($urandom_range(0, 99) < 50);
         iss_addr  = rnd_addr();
         rd_addr_a = rnd_addr();
         rd_addr_b = rnd_addr();
         cycle_check();
      end
      a_valid = 1'b0; m_valid = 1'b0; iss_valid = 1'b0;
      cycle_check();

      // Clear the scoreboard with a reset pulse between edges.
      rst = 1'b1;
      #1;
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;

      // Fill busy with r1..r15 and finish with a write so wr_en is high going into reset.
      for (int r = 1; r <= 15; r++) begin
         iss_valid = 1'b1; iss_addr = 5'(r);
         if (r == 15) begin
            a_valid = 1'b1; a_addr = 5'd20; a_data = 32'h2020_0014;
         end
         cycle_check();
      end
      iss_valid = 1'b0; a_valid = 1'b0;
      check("fill_busy",  busy, 32'h0000_FFFE);
      check("fill_wr_en", {31'd0, wr_en}, 32'd1);

      // Asynchronous reset mid-cycle with both requesters pending.
      a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h3333_0003;
      m_valid = 1'b1; m_addr = 5'd4; m_data = 32'h4444_0004;
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_busy",    busy, 32'd0);
      check("async_rst_wr_en",   {31'd0, wr_en}, 32'd0);
      check("async_rst_wr_data", wr_data, 32'd0);
      check("async_rst_a_ready", {31'd0, a_ready}, 32'd0);
      check("async_rst_m_ready", {31'd0, m_ready}, 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      check("held_rst_a_ready", {31'd0, a_ready}, 32'd0);
      check("held_rst_m_ready", {31'd0, m_ready}, 32'd0);
      check("held_rst_wr_en",   {31'd0, wr_en}, 32'd0);
      a_valid = 1'b0; m_valid = 1'b0;
      rst = 1'b0;
      cycle_check();
      cycle_check();

      // The first conflict after reset again goes to memory.
      a_valid = 1'b1; a_addr = 5'd11; a_data = 32'h1111_000B;
      m_valid = 1'b1; m_addr = 5'd12; m_data = 32'h2222_000C;
      cycle_check();
      check("post_rst_conflict_wr_addr", {27'd0, wr_addr}, 32'd12);
      m_valid = 1'b0;
      cycle_check();
      a_valid = 1'b0;
      cycle_check();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameters: none; data width 32, address width 5 and 31 writable registers (r1-r31, r0 hard-wired 0) are fixed.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 a_valid  in  1  ALU writeback request.
REQ-005 a_addr  in  5  ALU destination register.
REQ-006 a_data  in  32  ALU result.
REQ-007 a_ready  out  1  ALU request accepted this cycle (combinational).
REQ-008 m_valid / m_addr[4:0] / m_data[31:0]  in  memory-load writeback request, same meaning as a_*.
REQ-009 m_ready  out  1  memory request accepted this cycle (combinational).
REQ-010 iss_valid  in  1  instruction issued that will write iss_addr later.
REQ-011 iss_addr  in  5  destination to mark pending.
REQ-012 rd_addr_a, rd_addr_b  in  5 each  register-file read addresses being decoded.
REQ-013 hazard_a, hazard_b  out  1 each  read address has a pending write (combinational).
REQ-014 wr_en  out  1  register-file write enable (drives L_S).
REQ-015 wr_addr  out  5  register-file write address.
REQ-016 wr_data  out  32  register-file write data.
REQ-017 busy  out  32  pending-write scoreboard, bit i = register i.

Function
REQ-018 Handshake: transfer occurs when valid and ready both high at a rising edge; requester shall hold valid/addr/data stable until ready.
REQ-019 At most one of a_ready, m_ready shall be high in any cycle; ready is never high without its valid.
REQ-020 Only one valid: that requester is granted in the same cycle (ready = valid).
REQ-021 Both valid: round-robin; grant goes to the requester not granted most recently; pointer updates only on a transfer.
REQ-022 After reset the pointer shall favour m (first simultaneous conflict grants m).
REQ-023 Accepted request with addr != 0: wr_en=1, wr_addr, wr_data registered at that edge, visible for exactly one cycle (latency 1).
REQ-024 Accepted request with addr = 0: consumed (ready high, pointer advances), wr_en stays 0 next cycle.
REQ-025 No transfer in a cycle: wr_en=0 next cycle; wr_addr/wr_data hold previous values.
REQ-026 Back-to-back transfers shall produce wr_en high on consecutive cycles; throughput one write per cycle.
REQ-027 Scoreboard: iss_valid with iss_addr != 0 sets busy[iss_addr] at the edge; iss_addr = 0 ignored.
REQ-028 Transfer with addr != 0 clears busy[addr] at the same edge wr_* are registered.
REQ-029 Simultaneous set and clear of the same register: set wins (busy stays 1).
REQ-030 Set/clear of different registers in the same cycle both take effect.
REQ-031 Clear of a register not busy: no effect, write still performed.
REQ-032 busy[0] shall always read 0.
REQ-033 hazard_a = busy[rd_addr_a], hazard_b = busy[rd_addr_b]; address 0 never hazards.

Reset
REQ-034 rst high: wr_en=0, wr_addr=0, wr_data=0, busy=0, pointer favours m, within the same cycle regardless of clk.
REQ-035 rst mid-transfer: any pending request is dropped; no write emitted after rst deasserts until a new transfer.
REQ-036 a_ready/m_ready low while rst is high.

Verification
REQ-037 a_valid=1 a_addr=5 a_data=0x1234, m_valid=0 -> a_ready=1 same cycle; next cycle wr_en=1 wr_addr=5 wr_data=0x1234.
REQ-038 After reset, both valid (a_addr=3, m_addr=4) for two cycles -> m granted first, a second; wr_addr 4 then 3 on consecutive cycles.
REQ-039 iss_valid iss_addr=7, then rd_addr_a=7 -> hazard_a=1, busy=0x00000080; m writes r7 -> busy[7]=0 after the write edge, hazard_a=0.
REQ-040 Same cycle: iss_addr=9 and accepted a_addr=9 with busy[9]=1 -> busy[9] remains 1, wr_en=1 wr_addr=9.
REQ-041 a_addr=0 accepted -> a_ready=1, next cycle wr_en=0, busy[0]=0; iss_addr=0 -> busy unchanged.
REQ-042 rst asserted between clock edges with busy=0x0000FFFE -> busy=0, wr_en=0 immediately; both ready low until rst drops.
